// File: rtl/decision_trail.sv
// decision_trail: DPLL decision unit.
// Walks a static variable order and skips variables that are already assigned.
// Every decision is pushed onto a trail as {order slot, flipped}. On conflict
// the unit backtracks chronologically: fully explored levels are popped and the
// newest unflipped decision is flipped. When the order runs out, SAT is
// reported. When a conflict leaves no unflipped decision, UNSAT is reported.
module decision_trail #(
  parameter int NUM_VARS = 64,
  parameter int VAR_BITS = $clog2(NUM_VARS),
  parameter int LVL_BITS = $clog2(NUM_VARS + 1)
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [NUM_VARS*VAR_BITS-1:0] order_var_i,
  input  logic [NUM_VARS-1:0]          order_pol_i,
  input  logic [NUM_VARS-1:0]          assigned_i,
  input  logic                         dec_req_i,
  input  logic                         conflict_i,
  input  logic                         dec_ready_i,
  output logic                         dec_valid_o,
  output logic [VAR_BITS-1:0]          dec_var_o,
  output logic                         dec_val_o,
  output logic [LVL_BITS-1:0]          dec_level_o,
  output logic                         dec_flip_o,
  output logic                         busy_o,
  output logic                         sat_o,
  output logic                         unsat_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_BT,
    ST_EMIT,
    ST_DONE_SAT,
    ST_DONE_UNSAT
  } state_e;

  state_e                state_q;
  logic [LVL_BITS-1:0]   ptr_q;
  logic [LVL_BITS-1:0]   depth_q;
  logic [NUM_VARS-1:0]   trail_flip_q;
  logic [VAR_BITS-1:0]   trail_slot_q [NUM_VARS];

  logic                  dec_valid_q;
  logic [VAR_BITS-1:0]   dec_var_q;
  logic                  dec_val_q;
  logic [LVL_BITS-1:0]   dec_level_q;
  logic                  dec_flip_q;
  logic                  busy_q;
  logic                  sat_q;
  logic                  unsat_q;

  // The flat order bus is unpacked into one entry per slot.
  logic [VAR_BITS-1:0]   order_arr [NUM_VARS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VARS; gi++) begin : g_order
      assign order_arr[gi] = order_var_i[gi*VAR_BITS +: VAR_BITS];
    end
  endgenerate

  // The scan view is the order entry at ptr. Its index wraps when ptr == NUM_VARS,
  // but scan_done masks that case.
  logic [VAR_BITS-1:0]   ptr_idx;
  logic [VAR_BITS-1:0]   scan_var;
  logic                  scan_pol;
  logic                  scan_done;
  logic                  push_en;

  assign ptr_idx   = ptr_q[VAR_BITS-1:0];
  assign scan_var  = order_arr[ptr_idx];
  assign scan_pol  = order_pol_i[ptr_idx];
  assign scan_done = (ptr_q == LVL_BITS'(NUM_VARS));
  assign push_en   = (state_q == ST_SCAN) && !scan_done && !assigned_i[scan_var];

  // The backtrack view is the trail entry at depth-1. Its index wraps when
  // depth == 0, but the BT state checks depth first.
  logic [VAR_BITS-1:0]   top_idx;
  logic [VAR_BITS-1:0]   depth_idx;
  logic [VAR_BITS-1:0]   top_slot;
  logic                  top_flipped;
  logic [VAR_BITS-1:0]   top_var;
  logic                  top_pol;

  assign top_idx     = VAR_BITS'(depth_q - LVL_BITS'(1));
  assign depth_idx   = depth_q[VAR_BITS-1:0];
  assign top_slot    = trail_slot_q[top_idx];
  assign top_flipped = trail_flip_q[top_idx];
  assign top_var     = order_arr[top_slot];
  assign top_pol     = order_pol_i[top_slot];

  // The trail slot storage needs no reset: depth gates every read.
  always_ff @(posedge clock_i) begin
    if (push_en) begin
      trail_slot_q[depth_idx] <= ptr_idx;
    end
  end

  // Main decision FSM. Its outputs are registered.
  always_ff @(posedge clock_i) begin
    if (reset_i || start_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      depth_q      <= '0;
      trail_flip_q <= '0;
      dec_valid_q  <= 1'b0;
      dec_var_q    <= '0;
      dec_val_q    <= 1'b0;
      dec_level_q  <= '0;
      dec_flip_q   <= 1'b0;
      busy_q       <= 1'b0;
      sat_q        <= 1'b0;
      unsat_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Conflict wins over a simultaneous request.
          if (conflict_i) begin
            state_q <= ST_BT;
            busy_q  <= 1'b1;
          end else if (dec_req_i) begin
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_done) begin
            state_q <= ST_DONE_SAT;
            sat_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (assigned_i[scan_var]) begin
            ptr_q <= ptr_q + LVL_BITS'(1);
          end else begin
            trail_flip_q[depth_idx] <= 1'b0;
            depth_q     <= depth_q + LVL_BITS'(1);
            dec_var_q   <= scan_var;
            dec_val_q   <= scan_pol;
            dec_level_q <= depth_q + LVL_BITS'(1);
            dec_flip_q  <= 1'b0;
            dec_valid_q <= 1'b1;
            ptr_q       <= ptr_q + LVL_BITS'(1);
            state_q     <= ST_EMIT;
          end
        end
        ST_BT: begin
          if (depth_q == '0) begin
            state_q <= ST_DONE_UNSAT;
            unsat_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (top_flipped) begin
            depth_q <= depth_q - LVL_BITS'(1);
          end else begin
            trail_flip_q[top_idx] <= 1'b1;
            dec_var_q   <= top_var;
            dec_val_q   <= ~top_pol;
            dec_level_q <= depth_q;
            dec_flip_q  <= 1'b1;
            dec_valid_q <= 1'b1;
            ptr_q       <= LVL_BITS'(top_slot) + LVL_BITS'(1);
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (dec_ready_i) begin
            dec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_DONE_SAT, ST_DONE_UNSAT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dec_valid_o = dec_valid_q;
  assign dec_var_o   = dec_var_q;
  assign dec_val_o   = dec_val_q;
  assign dec_level_o = dec_level_q;
  assign dec_flip_o  = dec_flip_q;
  assign busy_o      = busy_q;
  assign sat_o       = sat_q;
  assign unsat_o     = unsat_q;

endmodule

// File: tb/tb_decision_trail.sv
// Testbench for decision_trail with NUM_VARS=4. The bench plays the Control role.
// The reference model keeps the trail as a queue of {slot, flipped} entries.
// A variable counts as assigned if it is in the static base set or belongs to
// any decision still on the trail.
module tb_decision_trail;
  localparam int NV = 4;
  localparam int VB = 2;
  localparam int LB = 3;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [NV*VB-1:0] order_var;
  logic [NV-1:0] order_pol, assigned;
  logic          dec_req, conflict, dec_ready;
  logic          dec_valid, dec_val, dec_flip, busy, sat, unsat;
  logic [VB-1:0] dec_var;
  logic [LB-1:0] dec_level;

  decision_trail #(.NUM_VARS(NV)) dut (
    .clock_i(clk), .reset_i(reset), .start_i(start),
    .order_var_i(order_var), .order_pol_i(order_pol), .assigned_i(assigned),
    .dec_req_i(dec_req), .conflict_i(conflict), .dec_ready_i(dec_ready),
    .dec_valid_o(dec_valid), .dec_var_o(dec_var), .dec_val_o(dec_val),
    .dec_level_o(dec_level), .dec_flip_o(dec_flip), .busy_o(busy),
    .sat_o(sat), .unsat_o(unsat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_order[NV];
  bit m_pol[NV];
  bit m_base[NV];
  int m_ptr;
  int m_tslot[$];
  bit m_tflip[$];

  // Expected result of the last operation: 0 = decision, 1 = sat, 2 = unsat
  int e_kind, e_var, e_val, e_lvl, e_flip, e_lat;

  function automatic bit is_asg(int v);
    if (m_base[v]) return 1'b1;
    foreach (m_tslot[k]) if (m_order[m_tslot[k]] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load_problem();
    for (int i = 0; i < NV; i++) begin
      order_var[i*VB +: VB] = m_order[i][VB-1:0];
      order_pol[i] = m_pol[i];
    end
    m_ptr = 0;
    m_tslot.delete();
    m_tflip.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic sync_assigned();
    for (int v = 0; v < NV; v++) assigned[v] = is_asg(v);
  endtask

  task automatic model_decide();
    int p;
    int sk;
    p = m_ptr;
    sk = 0;
    e_flip = 0;
    forever begin
      if (p == NV) begin
        e_kind = 1; e_lat = 2 + sk; m_ptr = p;
        break;
      end else if (is_asg(m_order[p])) begin
        sk++; p++;
      end else begin
        m_tslot.push_back(p); m_tflip.push_back(1'b0);
        e_kind = 0; e_var = m_order[p]; e_val = m_pol[p];
        e_lvl = m_tslot.size(); e_lat = 2 + sk; m_ptr = p + 1;
        break;
      end
    end
  endtask

  task automatic model_conflict();
    int pops;
    pops = 0;
    while (m_tslot.size() > 0 && m_tflip[m_tslot.size()-1]) begin
      void'(m_tslot.pop_back()); void'(m_tflip.pop_back()); pops++;
    end
    e_lat = 2 + pops;
    e_flip = 1;
    if (m_tslot.size() == 0) begin
      e_kind = 2;
    end else begin
      e_kind = 0;
      m_tflip[m_tslot.size()-1] = 1'b1;
      e_var = m_order[m_tslot[m_tslot.size()-1]];
      e_val = !m_pol[m_tslot[m_tslot.size()-1]];
      e_lvl = m_tslot.size();
      m_ptr = m_tslot[m_tslot.size()-1] + 1;
    end
  endtask

  // Pulses req/conflict for one cycle, then counts cycles (bounded) until a
  // result appears.
  task automatic issue(input bit req, input bit conf, output int lat);
    @(negedge clk); dec_req = req; conflict = conf;
    @(negedge clk); dec_req = 1'b0; conflict = 1'b0;
    lat = 1;
    while (!dec_valid && !sat && !unsat && lat < 64) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic accept(input int delay);
    repeat (delay) @(negedge clk);
    dec_ready = 1'b1;
    @(negedge clk); dec_ready = 1'b0;
  endtask

  task automatic set_spec_problem();
    m_order = '{2, 0, 3, 1};
    m_pol   = '{1, 0, 1, 0};
    m_base  = '{0, 0, 0, 0};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({dec_valid, dec_var, dec_val, dec_level, dec_flip, busy, sat, unsat} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required all zero",
               {dec_valid, dec_var, dec_val, dec_level, dec_flip, busy, sat, unsat});
    end
  endtask

  task automatic test_decide();
    int lat;
    set_spec_problem();
    load_problem();
    sync_assigned();
    issue(1, 0, lat); model_decide();
    tests++;
    if ({lat, 32'(dec_valid), 32'(dec_var), 32'(dec_val), 32'(dec_level), 32'(dec_flip)} !== {32'd2, 32'd1, 32'd2, 32'd1, 32'd1, 32'd0}) begin
      fails++;
      $display("FAIL decide_first: got lat=%0d v=%0d var=%0d val=%0d lvl=%0d flip=%0d required lat=2 v=1 var=2 val=1 lvl=1 flip=0",
               lat, dec_valid, dec_var, dec_val, dec_level, dec_flip);
    end
    accept(0);
    tests++;
    if (dec_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL handshake_drop: got valid=%0d busy=%0d required 0 0", dec_valid, busy);
    end
    // Propagation also assigned var0.
    m_base[0] = 1'b1;
    sync_assigned();
    issue(1, 0, lat); model_decide();
    tests++;
    if ({lat, 32'(dec_var), 32'(dec_val), 32'(dec_level), 32'(dec_flip)} !== {32'd3, 32'd3, 32'd1, 32'd2, 32'd0}) begin
      fails++;
      $display("FAIL decide_skip: got lat=%0d var=%0d val=%0d lvl=%0d flip=%0d required lat=3 var=3 val=1 lvl=2 flip=0",
               lat, dec_var, dec_val, dec_level, dec_flip);
    end
    accept(0);
  endtask

  task automatic test_backtrack();
    int lat;
    sync_assigned();
    issue(0, 1, lat); model_conflict();
    tests++;
    if ({lat, 32'(dec_var), 32'(dec_val), 32'(dec_level), 32'(dec_flip)} !== {32'd2, 32'd3, 32'd0, 32'd2, 32'd1}) begin
      fails++;
      $display("FAIL bt_flip_top: got lat=%0d var=%0d val=%0d lvl=%0d flip=%0d required lat=2 var=3 val=0 lvl=2 flip=1",
               lat, dec_var, dec_val, dec_level, dec_flip);
    end
    accept(0);
    sync_assigned();
    issue(0, 1, lat); model_conflict();
    tests++;
    if ({lat, 32'(dec_var), 32'(dec_val), 32'(dec_level), 32'(dec_flip)} !== {32'd3, 32'd2, 32'd0, 32'd1, 32'd1}) begin
      fails++;
      $display("FAIL bt_pop_flip: got lat=%0d var=%0d val=%0d lvl=%0d flip=%0d required lat=3 var=2 val=0 lvl=1 flip=1",
               lat, dec_var, dec_val, dec_level, dec_flip);
    end
    accept(0);
  endtask

  task automatic test_unsat();
    int lat;
    sync_assigned();
    issue(0, 1, lat); model_conflict();
    tests++;
    if ({lat, 32'(unsat), 32'(sat), 32'(busy), 32'(dec_valid)} !== {32'd3, 32'd1, 32'd0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL unsat_reach: got lat=%0d unsat=%0d sat=%0d busy=%0d valid=%0d required 3 1 0 0 0",
               lat, unsat, sat, busy, dec_valid);
    end
    issue(1, 0, lat);
    repeat (4) @(negedge clk);
    issue(0, 1, lat);
    repeat (4) @(negedge clk);
    tests++;
    if ({dec_valid, busy, unsat} !== 3'b001) begin
      fails++;
      $display("FAIL unsat_sticky: got valid=%0d busy=%0d unsat=%0d required 0 0 1", dec_valid, busy, unsat);
    end
    load_problem();
    tests++;
    if (unsat !== 1'b0) begin
      fails++;
      $display("FAIL start_clears_unsat: got %0d required 0", unsat);
    end
  endtask

  task automatic test_sat_and_priority();
    int lat;
    set_spec_problem();
    m_base = '{1, 1, 1, 1};
    load_problem();
    sync_assigned();
    issue(1, 0, lat); model_decide();
    tests++;
    if ({lat, 32'(sat), 32'(unsat), 32'(busy), 32'(dec_valid)} !== {32'(NV + 2), 32'd1, 32'd0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL sat_reach: got lat=%0d sat=%0d unsat=%0d busy=%0d valid=%0d required %0d 1 0 0 0",
               lat, sat, unsat, busy, dec_valid, NV + 2);
    end
    set_spec_problem();
    load_problem();
    sync_assigned();
    issue(1, 1, lat);
    tests++;
    if ({lat, 32'(unsat), 32'(sat), 32'(dec_valid)} !== {32'd2, 32'd1, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL conflict_priority: got lat=%0d unsat=%0d sat=%0d valid=%0d required 2 1 0 0",
               lat, unsat, sat, dec_valid);
    end
  endtask

  task automatic test_stall_and_abort();
    int lat;
    set_spec_problem();
    load_problem();
    sync_assigned();
    issue(1, 0, lat); model_decide();
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({dec_valid, dec_var, dec_val, dec_level, dec_flip, busy} !== {1'b1, 2'd2, 1'b1, 3'd1, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL stall_stable[%0d]: got v=%0d var=%0d val=%0d lvl=%0d flip=%0d busy=%0d required 1 2 1 1 0 1",
                 c, dec_valid, dec_var, dec_val, dec_level, dec_flip, busy);
      end
      @(negedge clk);
    end
    accept(0);
    sync_assigned();
    issue(1, 0, lat);
    // Abort while a decision is pending.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if ({dec_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL abort_emit: got valid=%0d busy=%0d required 0 0", dec_valid, busy);
    end
    m_ptr = 0; m_tslot.delete(); m_tflip.delete();
    sync_assigned();
    issue(1, 0, lat); model_decide();
    tests++;
    if ({lat, 32'(dec_var), 32'(dec_level)} !== {32'd2, 32'd2, 32'd1}) begin
      fails++;
      $display("FAIL after_abort_emit: got lat=%0d var=%0d lvl=%0d required 2 2 1", lat, dec_var, dec_level);
    end
    accept(0);
    sync_assigned();
    issue(0, 1, lat); model_conflict();
    accept(0);
    // The next conflict enters BT with one flipped entry. It is aborted in BT.
    @(negedge clk); conflict = 1'b1;
    @(negedge clk); conflict = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({dec_valid, busy, unsat} !== 3'b000) begin
      fails++;
      $display("FAIL abort_bt: got valid=%0d busy=%0d unsat=%0d required 0 0 0", dec_valid, busy, unsat);
    end
    m_ptr = 0; m_tslot.delete(); m_tflip.delete();
    sync_assigned();
    issue(1, 0, lat); model_decide();
    tests++;
    if ({lat, 32'(dec_var), 32'(dec_val), 32'(dec_level), 32'(dec_flip)} !== {32'd2, 32'd2, 32'd1, 32'd1, 32'd0}) begin
      fails++;
      $display("FAIL after_abort_bt: got lat=%0d var=%0d val=%0d lvl=%0d flip=%0d required 2 2 1 1 0",
               lat, dec_var, dec_val, dec_level, dec_flip);
    end
    accept(0);
  endtask

  task automatic test_random();
    int lat;
    bit op_conf;
    for (int prob = 0; prob < 40; prob++) begin
      for (int i = 0; i < NV; i++) begin
        m_order[i] = $urandom_range(0, NV - 1);
        m_pol[i]   = 1'($urandom_range(0, 1));
        m_base[i]  = ($urandom_range(0, 3) == 0);
      end
      load_problem();
      for (int op = 0; op < 30; op++) begin
        sync_assigned();
        op_conf = ($urandom_range(0, 9) < 3);
        issue(!op_conf, op_conf, lat);
        if (op_conf) model_conflict(); else model_decide();
        tests++;
        if (e_kind == 0) begin
          if ({lat, 32'(dec_valid), 32'(dec_var), 32'(dec_val), 32'(dec_level), 32'(dec_flip)} !==
              {e_lat, 32'd1, e_var, e_val, e_lvl, e_flip}) begin
            fails++;
            $display("FAIL rand_decision p%0d o%0d: got lat=%0d v=%0d var=%0d val=%0d lvl=%0d flip=%0d required lat=%0d v=1 var=%0d val=%0d lvl=%0d flip=%0d",
                     prob, op, lat, dec_valid, dec_var, dec_val, dec_level, dec_flip, e_lat, e_var, e_val, e_lvl, e_flip);
          end
          accept($urandom_range(0, 3));
        end else begin
          if ({lat, 32'(sat), 32'(unsat), 32'(busy)} !== {e_lat, 32'(e_kind == 1), 32'(e_kind == 2), 32'd0}) begin
            fails++;
            $display("FAIL rand_done p%0d o%0d: got lat=%0d sat=%0d unsat=%0d busy=%0d required lat=%0d sat=%0d unsat=%0d busy=0",
                     prob, op, lat, sat, unsat, busy, e_lat, e_kind == 1, e_kind == 2);
          end
          break;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dec_req = 1'b0; conflict = 1'b0; dec_ready = 1'b0;
    order_var = '0; order_pol = '0; assigned = '0;
    test_reset();
    test_decide();
    test_backtrack();
    test_unsat();
    test_sat_and_priority();
    test_stall_and_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
